// File: rtl/word_fifo.sv
// First-word-fall-through word FIFO; a pushed word is visible on rd_data right after its write edge.
// Never stalls upstream. Pushes while full are dropped and latched into the sticky ovf flag.
module word_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       afull,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              push;
  logic              pop;
  logic              drop;

  // All flags come from the count register, so rd_ready never reaches wr_ready.
  assign wr_ready = (cnt != FULL_CNT);
  assign rd_valid = (cnt != '0);
  assign afull    = (cnt >= AFULL_CNT);
  assign count    = cnt;
  assign rd_data  = mem[rd_ptr];

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;
  assign drop = wr_valid && !wr_ready;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear still leaves ovf set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_word_fifo.sv
// Directed bench for word_fifo at DEPTH=4, AFULL_LVL=4: vector table plus hand sequences.
module tb_word_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  count;
  logic        afull;
  logic        ovf;
  logic        ovf_clr;

  int n_cmp;
  int n_err;

  word_fifo #(.DATA_W(32), .DEPTH(4), .AFULL_LVL(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .afull    (afull),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        oc;
    logic [2:0]  c;
    logic        rv;
    logic        wr;
    logic        af;
    logic        ov;
    logic        cd;
    logic [31:0] d;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [31:0] wd, input logic rr,
                              input logic oc, input logic [2:0] c, input logic rv,
                              input logic wr, input logic af, input logic ov,
                              input logic cd, input logic [31:0] d);
    vec_t v;
    v.wv = wv; v.wd = wd; v.rr = rr; v.oc = oc;
    v.c = c; v.rv = rv; v.wr = wr; v.af = af; v.ov = ov; v.cd = cd; v.d = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] c, input logic rv,
                           input logic wr, input logic af, input logic ov);
    chk({tag, " count"},    32'(count),    32'(c));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(rv));
    chk({tag, " wr_ready"}, 32'(wr_ready), 32'(wr));
    chk({tag, " afull"},    32'(afull),    32'(af));
    chk({tag, " ovf"},      32'(ovf),      32'(ov));
  endtask

  // Drive inputs at a negedge, let one rising edge pass, return at the next negedge.
  task automatic step(input logic wv, input logic [31:0] wd, input logic rr, input logic oc);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    ovf_clr  = oc;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[13];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b0;
    ovf_clr = 1'b0;

    //                wv  wd            rr  oc  c  rv wr af ov cd d
    vecs[0]  = mk(1, 32'h11111111, 0, 0, 1, 1, 1, 0, 0, 1, 32'h11111111);
    vecs[1]  = mk(1, 32'h22222222, 0, 0, 2, 1, 1, 0, 0, 1, 32'h11111111);
    vecs[2]  = mk(1, 32'h33333333, 0, 0, 3, 1, 1, 0, 0, 1, 32'h11111111);
    vecs[3]  = mk(1, 32'h44444444, 0, 0, 4, 1, 0, 1, 0, 1, 32'h11111111);
    vecs[4]  = mk(1, 32'h55555555, 0, 0, 4, 1, 0, 1, 1, 1, 32'h11111111);
    vecs[5]  = mk(1, 32'h66666666, 0, 1, 4, 1, 0, 1, 1, 1, 32'h11111111);
    vecs[6]  = mk(0, 32'h0,        0, 1, 4, 1, 0, 1, 0, 1, 32'h11111111);
    vecs[7]  = mk(0, 32'h0,        1, 0, 3, 1, 1, 0, 0, 1, 32'h22222222);
    vecs[8]  = mk(0, 32'h0,        1, 0, 2, 1, 1, 0, 0, 1, 32'h33333333);
    vecs[9]  = mk(0, 32'h0,        1, 0, 1, 1, 1, 0, 0, 1, 32'h44444444);
    vecs[10] = mk(0, 32'h0,        1, 0, 0, 0, 1, 0, 0, 0, 32'h0);
    vecs[11] = mk(0, 32'h0,        1, 0, 0, 0, 1, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0);

    repeat (2) @(negedge clk);
    chk_flags("reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_flags("post_reset", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].oc);
      chk_flags($sformatf("v%0d", i), vecs[i].c, vecs[i].rv, vecs[i].wr, vecs[i].af, vecs[i].ov);
      if (vecs[i].cd) begin
        chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].d);
      end
    end

    // Streaming through an empty FIFO across two pointer wraps.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
      chk($sformatf("stream%0d count", i), 32'(count), 32'd1);
      chk($sformatf("stream%0d rd_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("stream%0d rd_data", i), rd_data, 32'hA0 + 32'(i));
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_flags("stream_end", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Full with push and pop together: the pop completes, the push is dropped.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
    end
    chk_flags("full_b", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hB4, 1'b1, 1'b0);
    chk_flags("full_pop", 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("full_pop rd_data", rd_data, 32'hB1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain_b rd_data0", rd_data, 32'hB2);
    chk("drain_b ovf", 32'(ovf), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_b rd_data1", rd_data, 32'hB3);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_flags("drain_b_end", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Simultaneous push and pop at count 2.
    step(1'b1, 32'hC0, 1'b0, 1'b0);
    step(1'b1, 32'hC1, 1'b0, 1'b0);
    chk("pp_setup count", 32'(count), 32'd2);
    step(1'b1, 32'hBEEF, 1'b1, 1'b0);
    chk("pp count", 32'(count), 32'd2);
    chk("pp rd_data", rd_data, 32'hC1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("pp next rd_data", rd_data, 32'hBEEF);
    chk("pp next count", 32'(count), 32'd1);

    // Asynchronous reset mid-cycle, away from any clock edge.
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_flags("async_rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'hD0, 1'b0, 1'b0);
    chk_flags("after_rst", 3'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("after_rst rd_data", rd_data, 32'hD0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
